seg_scan_driver: RTL and testbench

//   Parametrised multiplexed seven-segment driver: NUM_DIGITS hex digits,

---
 rtl/seg_scan_driver.sv | 143 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner: hex decode, refresh divider, frame-aligned commit, per-digit blanking.
// Optional leading-zero blanking is compiled in with `define SEG_LZB_EN.
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int DIV_COUNT   = 50000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit POS_ACT_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic                    pending,
  output logic                    frame_done,
  output logic [6:0]              seg_display,
  output logic [NUM_DIGITS-1:0]   seg_position
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_COUNT - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_WIDTH-1:0]    div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] stage_data;
  logic [NUM_DIGITS-1:0]   stage_blank;
  logic [4*NUM_DIGITS-1:0] disp_data;
  logic [NUM_DIGITS-1:0]   disp_blank;
  logic                    live;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   pos_q;
  logic                    tick;
  logic                    wrap;
  logic                    commit;
  logic [NUM_DIGITS-1:0]   dark;
  logic [3:0]              cur_nib;
  logic                    cur_dark;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'h3F;
      4'h1: hex_decode = 7'h06;
      4'h2: hex_decode = 7'h5B;
      4'h3: hex_decode = 7'h4F;
      4'h4: hex_decode = 7'h66;
      4'h5: hex_decode = 7'h6D;
      4'h6: hex_decode = 7'h7D;
      4'h7: hex_decode = 7'h07;
      4'h8: hex_decode = 7'h7F;
      4'h9: hex_decode = 7'h6F;
      4'hA: hex_decode = 7'h77;
      4'hB: hex_decode = 7'h7C;
      4'hC: hex_decode = 7'h39;
      4'hD: hex_decode = 7'h5E;
      4'hE: hex_decode = 7'h79;
      default: hex_decode = 7'h71;
    endcase
  endfunction

  assign tick       = (div_cnt == DIV_LAST);
  assign wrap       = tick && (idx == IDX_LAST);
  assign frame_done = wrap;
  assign commit     = wrap && pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= wrap ? '0 : idx + IDX_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_WIDTH'(1);
    end
  end

  // A load on the wrap tick wins over the commit clearing pending, so the new value waits a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_data  <= '0;
      stage_blank <= '0;
      pending     <= 1'b0;
    end else if (load) begin
      stage_data  <= data_in;
      stage_blank <= blank_in;
      pending     <= 1'b1;
    end else if (commit) begin
      pending     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_data  <= '0;
      disp_blank <= '1;
      live       <= 1'b0;
    end else if (commit) begin
      disp_data  <= stage_data;
      disp_blank <= stage_blank;
      live       <= 1'b1;
    end
  end

`ifdef SEG_LZB_EN
  logic                  lead;
  logic [NUM_DIGITS-1:0] lzb;

  always_comb begin
    lzb  = '0;
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lead   = lead & (disp_data[4*i +: 4] == 4'h0);
      lzb[i] = lead;
    end
    dark = disp_blank | lzb;
  end
`else
  assign dark = disp_blank;
`endif

  assign cur_nib  = disp_data[4*int'(idx) +: 4];
  assign cur_dark = dark[idx];

  // Positions stay deasserted until the first commit so the display is fully dark after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= '0;
      pos_q <= '0;
    end else if (!live) begin
      seg_q <= '0;
      pos_q <= '0;
    end else begin
      seg_q <= cur_dark ? 7'h00 : hex_decode(cur_nib);
      pos_q <= NUM_DIGITS'(1) << idx;
    end
  end

  assign seg_display  = seg_q ^ {7{SEG_ACT_LOW}};
  assign seg_position = pos_q ^ {NUM_DIGITS{POS_ACT_LOW}};

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4 digits, 4 clocks per slot, active-low pins.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load = 1'b0;
  logic        pending;
  logic        frame_done;
  logic [6:0]  seg_display;
  logic [3:0]  seg_position;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(
    .NUM_DIGITS(4), .DIV_WIDTH(16), .DIV_COUNT(4), .SEG_ACT_LOW(1'b1), .POS_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .blank_in(blank_in), .load(load),
    .pending(pending), .frame_done(frame_done), .seg_display(seg_display),
    .seg_position(seg_position)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      blank;
    logic [3:0][6:0] seg;   // expected pins per digit, {d3,d2,d1,d0}
  } vec_t;

  vec_t vecs[7];

  localparam logic [3:0][6:0] ALL_DARK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_fd(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end while (frame_done !== 1'b1 && cnt < 100);
    chk("frame_done seen", 16'(frame_done), 16'h1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] b);
    @(negedge clk);
    data_in  = d;
    blank_in = b;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("pending after load", 16'(pending), 16'h1);
  endtask

  // Called at the negedge where frame_done is high; checks each slot of the following frame.
  task automatic check_frame(input string tag, input logic [3:0][6:0] exp, input bit live);
    logic [3:0] ep;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (d == 0) begin
        @(posedge clk);
      end else begin
        repeat (4) @(posedge clk);
      end
      @(negedge clk);
      ep = live ? 4'(~(4'b0001 << d)) : 4'hF;
      chk($sformatf("%s seg d%0d", tag, d), 16'(seg_display), 16'(exp[d]));
      chk($sformatf("%s pos d%0d", tag, d), 16'(seg_position), 16'(ep));
    end
  endtask

  initial begin
    int cnt;

    vecs[0] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{16'hABCD, 4'b0000, {7'h08, 7'h03, 7'h46, 7'h21}};
    vecs[2] = '{16'h5678, 4'b0101, {7'h12, 7'h7F, 7'h78, 7'h7F}};
    vecs[3] = '{16'h9EF0, 4'b0000, {7'h10, 7'h06, 7'h0E, 7'h40}};
`ifdef SEG_LZB_EN
    vecs[4] = '{16'h0050, 4'b0000, {7'h7F, 7'h7F, 7'h12, 7'h40}};
    vecs[5] = '{16'h0000, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
`else
    vecs[4] = '{16'h0050, 4'b0000, {7'h40, 7'h40, 7'h12, 7'h40}};
    vecs[5] = '{16'h0000, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}};
`endif
    vecs[6] = '{16'h8000, 4'b1000, {7'h7F, 7'h40, 7'h40, 7'h40}};

    #12;
    chk("reset seg", 16'(seg_display), 16'h7F);
    chk("reset pos", 16'(seg_position), 16'hF);
    chk("reset pending", 16'(pending), 16'h0);
    chk("reset frame_done", 16'(frame_done), 16'h0);
    @(negedge clk);
    rst = 1'b1;

    wait_fd(cnt);
    chk("first wrap latency", 16'(cnt), 16'd15);
    check_frame("dark after reset", ALL_DARK, 1'b0);
    chk("pending idle", 16'(pending), 16'h0);

    for (int v = 0; v < 7; v++) begin
      wait_fd(cnt);
      @(negedge clk);
      chk("frame_done one cycle", 16'(frame_done), 16'h0);
      data_in  = vecs[v].data;
      blank_in = vecs[v].blank;
      load     = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk($sformatf("vec%0d pending after load", v), 16'(pending), 16'h1);
      wait_fd(cnt);
      chk($sformatf("vec%0d pending at wrap", v), 16'(pending), 16'h1);
      check_frame($sformatf("vec%0d", v), vecs[v].seg, 1'b1);
      chk($sformatf("vec%0d pending cleared", v), 16'(pending), 16'h0);
    end

    // Two loads in one frame: only the later one is ever shown.
    wait_fd(cnt);
    do_load(16'h1111, 4'b0000);
    repeat (3) @(negedge clk);
    do_load(16'h2222, 4'b0000);
    wait_fd(cnt);
    chk("latest pending at wrap", 16'(pending), 16'h1);
    check_frame("latest wins", {7'h24, 7'h24, 7'h24, 7'h24}, 1'b1);
    chk("latest pending cleared", 16'(pending), 16'h0);

    // Load exactly on the wrap tick while another value is staged.
    wait_fd(cnt);
    do_load(16'h1234, 4'b0000);
    wait_fd(cnt);
    data_in = 16'hABCD;
    load    = 1'b1;
    check_frame("wrap load old", {7'h79, 7'h24, 7'h30, 7'h19}, 1'b1);
    chk("wrap load pending held", 16'(pending), 16'h1);
    wait_fd(cnt);
    check_frame("wrap load new", {7'h08, 7'h03, 7'h46, 7'h21}, 1'b1);
    chk("wrap load pending cleared", 16'(pending), 16'h0);

    // Asynchronous reset mid-frame with a value staged.
    do_load(16'h5555, 4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid reset seg", 16'(seg_display), 16'h7F);
    chk("mid reset pos", 16'(seg_position), 16'hF);
    chk("mid reset pending", 16'(pending), 16'h0);
    @(negedge clk);
    rst = 1'b1;
    wait_fd(cnt);
    chk("wrap latency after reset", 16'(cnt), 16'd15);
    check_frame("dark after mid reset", ALL_DARK, 1'b0);
    wait_fd(cnt);
    check_frame("still dark", ALL_DARK, 1'b0);
    do_load(16'h1234, 4'b0000);
    wait_fd(cnt);
    check_frame("after reset load", {7'h79, 7'h24, 7'h30, 7'h19}, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
